// File: rtl/led_sweep_checker.sv
// led_sweep_checker: passive monitor for the LED bounce sweep (LED1..LED4 + blink LED5).
// Locks onto the one-hot bounce sequence and checks step order, blink coincidence and dwell time.
// Optional feature macro: LED_SWEEP_CHECKER_HOLD_EN adds hold_in, which freezes the dwell timer.
module led_sweep_checker #(
  parameter int unsigned DWELL_MIN = 100,
  parameter int unsigned DWELL_MAX = 255,
  parameter int unsigned TMR_W     = 10,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       led_in,
  input  logic             blink_in,
`ifdef LED_SWEEP_CHECKER_HOLD_EN
  input  logic             hold_in,
`endif
  output logic [1:0]       pos,
  output logic             dir,
  output logic             locked,
  output logic [CNT_W-1:0] sweeps,
  output logic             err_onehot,
  output logic             err_step,
  output logic             err_blink,
  output logic             err_dwell
);

  typedef enum logic {S_SYNC, S_TRACK} state_t;

  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_SAT  = '1;
  localparam logic [TMR_W-1:0] TMR_DMIN = TMR_W'(DWELL_MIN);
  localparam logic [TMR_W-1:0] TMR_DMAX = TMR_W'(DWELL_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_led_q, r_led_p;
  logic             r_blink_q, r_blink_p;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [1:0]       r_pos, w_pos_nxt;
  logic             r_dir, w_dir_nxt;
  logic [CNT_W-1:0] r_sweeps, w_sweeps_nxt;
  logic             r_err_onehot, w_err_onehot_nxt;
  logic             r_err_step, w_err_step_nxt;
  logic             r_err_blink, w_err_blink_nxt;
  logic             r_err_dwell, w_err_dwell_nxt;

  logic             w_change, w_btog, w_q_onehot, w_p_onehot;
  logic             w_up, w_dn, w_end, w_hold;
  logic [3:0]       w_expected;
  logic [1:0]       w_idx;

`ifdef LED_SWEEP_CHECKER_HOLD_EN
  assign w_hold = hold_in;
`else
  assign w_hold = 1'b0;
`endif

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  assign w_change   = (r_led_q != r_led_p);
  assign w_btog     = (r_blink_q != r_blink_p);
  assign w_q_onehot = is_onehot(r_led_q);
  assign w_p_onehot = is_onehot(r_led_p);
  assign w_up       = (r_led_q == {r_led_p[2:0], 1'b0});
  assign w_dn       = (r_led_q == {1'b0, r_led_p[3:1]});
  assign w_expected = r_dir ? {1'b0, r_led_p[3:1]} : {r_led_p[2:0], 1'b0};
  assign w_end      = (r_led_q == 4'b1000) || (r_led_q == 4'b0001);

  // Bit index of the lit LED (only meaningful when r_led_q is one-hot)
  always_comb begin
    w_idx = 2'd0;
    case (r_led_q)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // Next-state and status update
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_pos_nxt        = r_pos;
    w_dir_nxt        = r_dir;
    w_sweeps_nxt     = r_sweeps;
    w_err_onehot_nxt = r_err_onehot;
    w_err_step_nxt   = r_err_step;
    w_err_blink_nxt  = r_err_blink;
    w_err_dwell_nxt  = r_err_dwell;
    case (r_state)
      S_SYNC: begin
        w_timer_nxt = '0;
        if (w_change && w_q_onehot && w_p_onehot && (w_up || w_dn) && w_btog) begin
          w_state_nxt = S_TRACK;
          w_pos_nxt   = w_idx;
          w_dir_nxt   = w_dn;
          w_timer_nxt = TMR_ONE;
          if (r_led_q == 4'b1000) w_dir_nxt = 1'b1;
          if (r_led_q == 4'b0001) w_dir_nxt = 1'b0;
          if (w_end && (r_sweeps != CNT_SAT)) w_sweeps_nxt = r_sweeps + CNT_W'(1);
        end
      end
      S_TRACK: begin
        if (w_change) begin
          if (!w_btog) w_err_blink_nxt = 1'b1;
          if (!w_hold && (r_timer < TMR_DMIN)) w_err_dwell_nxt = 1'b1;
          if (!w_q_onehot) begin
            w_err_onehot_nxt = 1'b1;
            w_state_nxt      = S_SYNC;
            w_timer_nxt      = '0;
          end else if (r_led_q != w_expected) begin
            w_err_step_nxt = 1'b1;
            w_state_nxt    = S_SYNC;
            w_timer_nxt    = '0;
          end else begin
            w_pos_nxt   = w_idx;
            w_timer_nxt = TMR_ONE;
            if (r_led_q == 4'b1000) w_dir_nxt = 1'b1;
            if (r_led_q == 4'b0001) w_dir_nxt = 1'b0;
            if (w_end && (r_sweeps != CNT_SAT)) w_sweeps_nxt = r_sweeps + CNT_W'(1);
          end
        end else begin
          if (w_btog) w_err_blink_nxt = 1'b1;
          if (!w_hold) begin
            if (r_timer != TMR_SAT) w_timer_nxt = r_timer + TMR_ONE;
            // timer about to become DWELL_MAX+1: stalled sweep
            if (r_timer == TMR_DMAX) w_err_dwell_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // Input capture and state/status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_SYNC;
      r_led_q      <= '0;
      r_led_p      <= '0;
      r_blink_q    <= 1'b0;
      r_blink_p    <= 1'b0;
      r_timer      <= '0;
      r_pos        <= '0;
      r_dir        <= 1'b0;
      r_sweeps     <= '0;
      r_err_onehot <= 1'b0;
      r_err_step   <= 1'b0;
      r_err_blink  <= 1'b0;
      r_err_dwell  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_led_q      <= led_in;
      r_led_p      <= r_led_q;
      r_blink_q    <= blink_in;
      r_blink_p    <= r_blink_q;
      r_timer      <= w_timer_nxt;
      r_pos        <= w_pos_nxt;
      r_dir        <= w_dir_nxt;
      r_sweeps     <= w_sweeps_nxt;
      r_err_onehot <= w_err_onehot_nxt;
      r_err_step   <= w_err_step_nxt;
      r_err_blink  <= w_err_blink_nxt;
      r_err_dwell  <= w_err_dwell_nxt;
    end
  end

  assign pos        = r_pos;
  assign dir        = r_dir;
  assign locked     = (r_state == S_TRACK);
  assign sweeps     = r_sweeps;
  assign err_onehot = r_err_onehot;
  assign err_step   = r_err_step;
  assign err_blink  = r_err_blink;
  assign err_dwell  = r_err_dwell;

endmodule

// File: tb/tb_led_sweep_checker.sv
// Directed bench for led_sweep_checker; inputs driven and outputs sampled on the falling edge.
module tb_led_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] led_in;
  logic       blink_in;
  logic       hold_in;
  logic [1:0] pos;
  logic       dir, locked;
  logic [7:0] sweeps;
  logic       err_onehot, err_step, err_blink, err_dwell;
  int         n_total = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;

  led_sweep_checker dut (
    .clk        (clk),
    .rst        (rst),
    .led_in     (led_in),
    .blink_in   (blink_in),
`ifdef LED_SWEEP_CHECKER_HOLD_EN
    .hold_in    (hold_in),
`endif
    .pos        (pos),
    .dir        (dir),
    .locked     (locked),
    .sweeps     (sweeps),
    .err_onehot (err_onehot),
    .err_step   (err_step),
    .err_blink  (err_blink),
    .err_dwell  (err_dwell)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] led, input logic tog);
    led_in = led;
    if (tog) blink_in = ~blink_in;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wn(2);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] errs();
    return 32'({err_onehot, err_step, err_blink, err_dwell});
  endfunction

  logic [3:0] seq  [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [1:0] epos [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
  logic       edir [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; led_in = 4'b0000; blink_in = 1'b0; hold_in = 1'b0;
    wn(1);
    do_reset();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_sweeps", 32'(sweeps), 0);
    chk("rst_errs", errs(), 0);

    // Ideal sweep, dwell 150, three full bounces
    drive(4'b0001, 1'b0); wn(150);
    chk("sync_no_lock", 32'(locked), 0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 6; i++) begin
        drive(seq[i], 1'b1); wn(2);
        if (b == 0 && i == 0) chk("first_lock", 32'(locked), 1);
        chk($sformatf("sw_pos_%0d_%0d", b, i), 32'(pos), 32'(epos[i]));
        chk($sformatf("sw_dir_%0d_%0d", b, i), 32'(dir), 32'(edir[i]));
        wn(148);
      end
    end
    chk("sw_sweeps", 32'(sweeps), 6);
    chk("sw_errs", errs(), 0);
    chk("sw_locked", 32'(locked), 1);

    // Wrong step at 0100 going up, then relock
    drive(4'b0010, 1'b1); wn(150);
    drive(4'b0100, 1'b1); wn(2);
    chk("pre_step_pos", 32'(pos), 2);
    wn(148);
    drive(4'b0010, 1'b1); wn(2);
    chk("step_locked", 32'(locked), 0);
    chk("step_errs", errs(), 32'b0100);
    chk("step_pos_hold", 32'(pos), 2);
    wn(148);
    drive(4'b0100, 1'b1); wn(2);
    chk("relock", 32'(locked), 1);
    chk("relock_pos", 32'(pos), 2);
    chk("relock_dir", 32'(dir), 0);
    chk("relock_errs", errs(), 32'b0100);
    chk("relock_sweeps", 32'(sweeps), 6);
    wn(148);

    // Non-one-hot pattern for one cycle
    drive(4'b0110, 1'b1); wn(1);
    drive(4'b0100, 1'b0); wn(1);
    chk("onehot_errs", errs(), 32'b1100);
    chk("onehot_locked", 32'(locked), 0);
    wn(150);
    drive(4'b1000, 1'b1); wn(2);
    chk("lock_end_locked", 32'(locked), 1);
    chk("lock_end_pos", 32'(pos), 3);
    chk("lock_end_dir", 32'(dir), 1);
    wn(50);

    // Reset while tracking
    rst = 1'b1; wn(1);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_pos", 32'(pos), 0);
    chk("midrst_dir", 32'(dir), 0);
    chk("midrst_sweeps", 32'(sweeps), 0);
    chk("midrst_errs", errs(), 0);
    rst = 1'b0;

    // Step without blink toggle
    drive(4'b0001, 1'b0); wn(150);
    drive(4'b0010, 1'b1); wn(150);
    drive(4'b0100, 1'b0); wn(2);
    chk("noblink_errs", errs(), 32'b0010);
    chk("noblink_pos", 32'(pos), 2);
    chk("noblink_locked", 32'(locked), 1);
    wn(20);

    // Blink toggle without a step
    do_reset();
    chk("rst2_errs", errs(), 0);
    drive(4'b0001, 1'b0); wn(150);
    drive(4'b0010, 1'b1); wn(50);
    drive(4'b0010, 1'b1); wn(2);
    chk("lone_blink_errs", errs(), 32'b0010);
    chk("lone_blink_locked", 32'(locked), 1);
    chk("lone_blink_pos", 32'(pos), 1);

    // Dwell 100 accepted, dwell 99 flagged
    do_reset();
    drive(4'b0001, 1'b0); wn(150);
    drive(4'b0010, 1'b1); wn(100);
    drive(4'b0100, 1'b1); wn(2);
    chk("dwell100_errs", errs(), 0);
    chk("dwell100_pos", 32'(pos), 2);
    wn(97);
    drive(4'b1000, 1'b1); wn(2);
    chk("dwell99_errs", errs(), 32'b0001);
    chk("dwell99_pos", 32'(pos), 3);
    chk("dwell99_dir", 32'(dir), 1);
    chk("dwell99_sweeps", 32'(sweeps), 1);
    chk("dwell99_locked", 32'(locked), 1);

    // Stall: flag raised the cycle the timer reaches DWELL_MAX+1
    do_reset();
    drive(4'b0001, 1'b0); wn(150);
    drive(4'b0010, 1'b1); wn(256);
    chk("stall_255", 32'(err_dwell), 0);
    wn(1);
    chk("stall_256", 32'(err_dwell), 1);
    chk("stall_locked", 32'(locked), 1);
    drive(4'b0100, 1'b1); wn(2);
    chk("late_pos", 32'(pos), 2);
    chk("late_locked", 32'(locked), 1);

`ifdef LED_SWEEP_CHECKER_HOLD_EN
    // Hold freezes the dwell timer, which then resumes
    do_reset();
    drive(4'b0001, 1'b0); wn(150);
    drive(4'b0010, 1'b1); wn(100);
    hold_in = 1'b1; wn(500);
    chk("hold_no_err", 32'(err_dwell), 0);
    chk("hold_locked", 32'(locked), 1);
    hold_in = 1'b0; wn(156);
    chk("resume_255", 32'(err_dwell), 0);
    wn(1);
    chk("resume_256", 32'(err_dwell), 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
